uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It is the next-generation replacement for the fixed 8-bit transmitter on the chain-code encoder-to-decoder serial link. Character width, FIFO depth, baud divisor and stop-bit count are set by parameters, and parity is selectable at compile time. Upstream producers such as the chain-code encoder push symbols at full clock rate, and the block serialises them back-to-back onto `tx_out`.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter with integrated FIFO.
package uart_pkg;

    localparam int MAX_DATA_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Index width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO feeding the UART transmitter; head entry is presented combinationally.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    // Full is the registered flag, so a push while full is dropped even when a pop frees a slot.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated FIFO; back-to-back characters with no idle gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for data and tx_en
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | even parity bit (UART_TX_PARITY_EN only)
// ST_STOP   | stop bit(s), high; may chain straight into START
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 10,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       tx_en,
    input  logic                       clr_ovf,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       tx_out
);

    localparam int BAUD_W = width_of(CLKS_PER_BIT);
    localparam int BIT_W  = width_of(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam tx_state_t AFTER_DATA = ST_STOP;
`endif

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, ovf_q;
    logic              pop, can_pop, bit_done;
    logic [DATA_W-1:0] head;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    uart_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign can_pop  = !empty && tx_en;
    assign bit_done = (baud_q == '0);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q - BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_LAST;
                if (can_pop) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_d  = BAUD_LAST;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d  = BAUD_LAST;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = AFTER_DATA;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    baud_d  = BAUD_LAST;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (can_pop) begin
                            pop     = 1'b1;
                            shift_d = head;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        // Parity is latched with the character because the shift register is consumed.
        if (pop) par_d = even_parity(MAX_DATA_W'(head));
`endif
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_out   = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected characters, a line monitor checks each frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB = 10;
    // 1+8+P+1 bits for the main instance, 1+7+P+2 for the second: both 10+P bits
    localparam int LEN = (10 + P) * CPB;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0, tx_en = 1'b1, clr_ovf = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, empty, overflow, busy, tx_out;
    logic [2:0] count;

    logic       wr_en2 = 1'b0, tx_en2 = 1'b1, clr_ovf2 = 1'b0;
    logic [6:0] wr_data2 = '0;
    logic       full2, empty2, ovf2, busy2, tx_out2;
    logic [2:0] count2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t expq[$];
    int   starts_q[$];

    uart_tx_fifo #(.DATA_W(8), .DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_en(tx_en),
        .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .busy(busy), .tx_out(tx_out)
    );

    uart_tx_fifo #(.DATA_W(7), .DEPTH(4), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2), .tx_en(tx_en2),
        .clr_ovf(clr_ovf2), .full(full2), .empty(empty2), .count(count2),
        .overflow(ovf2), .busy(busy2), .tx_out(tx_out2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic fbit(input exp_t e, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (P == 1 && b == 9) return e.par;
        return 1'b1;
    endfunction

    // Line monitor: every start bit pops one expected character and checks the whole frame cycle by cycle.
    initial begin : monitor
        exp_t e;
        int   first_bad;
        logic got;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (!reset && tx_out === 1'b0) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected_start: got start at cycle %0d expected none", cyc);
                    repeat (LEN - 1) @(negedge clk);
                end else begin
                    e = expq.pop_front();
                    starts_q.push_back(cyc);
                    first_bad = -1;
                    got = 1'b0;
                    aborted = 1'b0;
                    for (int k = 0; k < LEN; k++) begin
                        if (k > 0) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_out !== fbit(e, k) && first_bad < 0) begin
                            first_bad = k;
                            got = tx_out;
                        end
                    end
                    if (!aborted) begin
                        total++;
                        if (first_bad >= 0) begin
                            bad++;
                            $display("FAIL mon_frame data=%h: at frame cycle %0d got %b expected %b",
                                     e.data, first_bad, got, fbit(e, first_bad));
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic write(input logic [7:0] d, output int n);
        wr_en = 1'b1;
        wr_data = d;
        n = cyc;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((expq.size() != 0 || busy !== 1'b0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_drained"}, (expq.size() == 0 && busy === 1'b0), 1);
    endtask

    task automatic chk_gaps(input string name, input int n);
        chk({name, "_nstarts"}, starts_q.size(), n);
        for (int i = 1; i < starts_q.size(); i++)
            chk({name, "_start_spacing"}, starts_q[i] - starts_q[i-1], LEN);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no completion expected finish within 30000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int   n, n0, first, hi;
        logic [4:0]  ovf_par;
        logic [10+P-1:0] f2;
        ovf_par = 5'b01011;   // parity of 0x05..0x01 (MSB..LSB)
`ifdef UART_TX_PARITY_EN
        f2 = 11'b11_0_1010101_0;
`else
        f2 = 10'b11_1010101_0;
`endif

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        at_neg(cyc);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);

        // single character 0xA5
        starts_q.delete();
        expq.push_back('{8'hA5, 1'b0});
        write(8'hA5, n);
        at_neg(n + 1);
        chk("single_empty_fall", empty, 0);
        chk("single_busy_before_pop", busy, 0);
        at_neg(n + 2);
        chk("single_busy_rise", busy, 1);
        chk("single_tx_start", tx_out, 0);
        at_neg(n + 1 + LEN);
        chk("single_busy_last", busy, 1);
        at_neg(n + 2 + LEN);
        chk("single_busy_drop", busy, 0);
        chk("single_line_idle", tx_out, 1);
        chk("single_start_cycle", starts_q[0], n + 2);

        // overflow: six writes into a 4-deep FIFO while transmitting
        starts_q.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) expq.push_back('{8'(i), ovf_par[i-1]});
            write(8'(i), n);
        end
        at_neg(n + 1);
        chk("ovf_flag_set", overflow, 1);
        chk("ovf_count_full", count, 4);
        chk("ovf_full", full, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        at_neg(cyc);
        chk("ovf_cleared", overflow, 0);
        drain("ovf");
        chk_gaps("ovf", 5);

        // tx_en hold, then set-wins overflow, then release
        tx_en = 1'b0;
        starts_q.delete();
        expq.push_back('{8'h11, 1'b0});
        write(8'h11, n);
        expq.push_back('{8'h22, 1'b0});
        write(8'h22, n);
        expq.push_back('{8'h33, 1'b0});
        write(8'h33, n);
        at_neg(n + 1);
        chk("hold_count3", count, 3);
        hi = 1;
        repeat (20) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || busy !== 1'b0) hi = 0;
        end
        chk("hold_line_idle", hi, 1);
        expq.push_back('{8'h44, 1'b0});
        write(8'h44, n);
        at_neg(n + 1);
        chk("hold_full", full, 1);
        clr_ovf = 1'b1;
        write(8'h55, n);
        clr_ovf = 1'b0;
        at_neg(n + 1);
        chk("ovf_set_wins", overflow, 1);
        chk("hold_count_after_drop", count, 4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        at_neg(cyc);
        chk("ovf_cleared2", overflow, 0);
        tx_en = 1'b1;
        drain("hold");
        chk_gaps("hold", 4);

        // reset during data bit 3 of 0x07 (bit 3 is 0)
        starts_q.delete();
        expq.push_back('{8'h07, 1'b1});
        expq.push_back('{8'h77, 1'b0});
        write(8'h07, n0);
        write(8'h77, n);
        at_neg(n0 + 45);
        chk("rm_bit3_low", tx_out, 0);
        reset = 1'b1;
        #1;
        chk("rm_tx_high", tx_out, 1);
        chk("rm_count", count, 0);
        chk("rm_busy", busy, 0);
        chk("rm_empty", empty, 1);
        expq.delete();
        repeat (2) step();
        reset = 1'b0;
        starts_q.delete();
        expq.push_back('{8'h3C, 1'b0});
        write(8'h3C, n);
        drain("post_reset");
        chk_gaps("post_reset", 1);
        chk("post_reset_start", starts_q[0], n + 2);

        // 7-bit character, two stop bits, on the second instance
        wr_en2 = 1'b1;
        wr_data2 = 7'h55;
        n = cyc;
        step();
        wr_en2 = 1'b0;
        first = -1;
        for (int k = 0; k < LEN; k++) begin
            at_neg(n + 2 + k);
            if (tx_out2 !== f2[k / CPB] && first < 0) first = k;
        end
        chk("d2_frame_first_bad", first, -1);
        at_neg(n + 2 + LEN);
        chk("d2_busy_drop", busy2, 0);
        chk("d2_line_idle", tx_out2, 1);

        chk("sb_leftover", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
